// File: rtl/button_events_pkg.sv
// Shared definitions for the button-path blocks: event codes, FSM state
// encoding and the event code width.
package button_events_pkg;

    localparam int EV_W = 2;

    typedef enum logic [EV_W-1:0] {
        EV_CLICK    = 2'd0,
        EV_DOUBLE   = 2'd1,
        EV_LONG     = 2'd2,
        EV_LONG_END = 2'd3
    } ev_code_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRESSED   = 3'd1,
        ST_LONG_HELD = 3'd2,
        ST_WAIT_DBL  = 3'd3,
        ST_PRESSED2  = 3'd4
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/evt_fifo.sv
// Small synchronous FIFO with a combinational head output. A push into a
// full FIFO is accepted only when a pop happens on the same edge.
module evt_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB separates "full" from "empty" when the indices match.
    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end

    assign pop_data = mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/button_events.sv
// Turns a debounced button level into CLICK / DOUBLE / LONG / LONG_END
// events, queued in a small FIFO with a sticky overflow flag.
module button_events
    import button_events_pkg::*;
#(
    parameter int LONG_CKS   = 16,
    parameter int DCLK_CKS   = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            gch_clk,
    input  logic            gch_reset,
    output logic            gch_ready,
    input  logic            steady,
    output logic            ev_valid,
    output logic [EV_W-1:0] ev_code,
    input  logic            ev_ready,
    output logic            ev_ovf,
    input  logic            ovf_clr
);
    localparam int CNT_W = $clog2(max_int(LONG_CKS, DCLK_CKS)) + 1;
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CKS - 1);
    localparam logic [CNT_W-1:0] DCLK_LAST = CNT_W'(DCLK_CKS - 1);

    state_t          state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
    logic            prev_reg;
    logic            ready_reg;
    logic            ovf_reg;
    logic            rise, fall;
    logic            push, pop, drop;
    ev_code_t        push_code;
    logic            full, empty;
    logic [EV_W-1:0] head;

    // Edges are ignored on the first edge after reset so a button held at
    // start-up is only learned, never reported.
    assign rise    = ready_reg & steady & ~prev_reg;
    assign fall    = ready_reg & ~steady & prev_reg;
    assign cnt_inc = (&cnt_reg) ? cnt_reg : cnt_reg + 1'b1;

    always_ff @(posedge gch_clk or negedge gch_reset) begin
        if (!gch_reset) begin
            ready_reg <= 1'b0;
            prev_reg  <= 1'b0;
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            ready_reg <= 1'b1;
            prev_reg  <= steady;
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            ovf_reg   <= drop | (ovf_reg & ~ovf_clr);
        end
    end

    // Edges are tested before timeouts so a coinciding edge wins.
    always_comb begin
        state_next = state_reg;
        cnt_next   = '0;
        push       = 1'b0;
        push_code  = EV_CLICK;
        case (state_reg)
            ST_IDLE: begin
                if (rise) state_next = ST_PRESSED;
            end
            ST_PRESSED: begin
                if (fall) begin
                    state_next = ST_WAIT_DBL;
                end else if (cnt_reg == LONG_LAST && steady) begin
                    push       = 1'b1;
                    push_code  = EV_LONG;
                    state_next = ST_LONG_HELD;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            ST_LONG_HELD: begin
                if (fall) begin
                    push       = 1'b1;
                    push_code  = EV_LONG_END;
                    state_next = ST_IDLE;
                end
            end
            ST_WAIT_DBL: begin
                if (rise) begin
                    state_next = ST_PRESSED2;
                end else if (cnt_reg == DCLK_LAST) begin
                    push       = 1'b1;
                    push_code  = EV_CLICK;
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            ST_PRESSED2: begin
                if (fall) begin
                    push       = 1'b1;
                    push_code  = EV_DOUBLE;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign pop  = ~empty & ev_ready;
    assign drop = push & full & ~pop;

    evt_fifo #(
        .WIDTH (EV_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (gch_clk),
        .rst_n     (gch_reset),
        .push      (push),
        .push_data (push_code),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty)
    );

    assign gch_ready = ready_reg;
    assign ev_valid  = ~empty;
    assign ev_code   = empty ? '0 : head;
    assign ev_ovf    = ovf_reg;

endmodule
